// File: rtl/ebus_diag_pkg.sv
// Shared types and constants for the console EBUS diagnostic sequencer.
package ebus_diag_pkg;

  typedef enum logic [2:0] {
    DIAG_IDLE,
    DIAG_SETUP,
    DIAG_STROBE,
    DIAG_HOLD,
    DIAG_DONE
  } diagSeqStateT;

  localparam logic [6:0] diagLdFunc076 = 7'o076;
  localparam logic [6:0] diagClkEdp    = 7'o077;
  localparam logic [6:0] diagRdFunc10x = 7'o100;

  // DEC numbers ds[0:6] MSB-first, so ds[0] is bit 6 of the packed code here.
  function automatic logic isDiagRead(input logic [6:0] func);
    return func[6];
  endfunction

endpackage

// File: rtl/ebus_diag_seq.sv
// Console diagnostic-function sequencer: drives ds/data/diagStrobe through setup, strobe, hold.
// Latency S+T+H+1 cycles accept-to-rsp_valid; req_ready low while busy or microcode owns the port.
module ebus_diag_seq
  import ebus_diag_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_func,
  input  logic [35:0] req_wdata,
  input  logic        ucode_diag,
  output logic        rsp_valid,
  output logic [35:0] rsp_rdata,
  output logic        busy,
  output logic [6:0]  ebus_ds,
  output logic        ebus_diag_strobe,
  output logic [35:0] ebus_data_out,
  output logic        ebus_data_drive,
  input  logic [35:0] ebus_data_in
);

  localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES)
                         ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                         : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAX_CYC + 1);

  // Counter holds "cycles remaining after this one" so a phase ends when it reads 0.
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

  diagSeqStateT    state;
  logic [CW-1:0]   cnt;
  logic            rd_q;

  assign req_ready = (state == DIAG_IDLE) && !ucode_diag;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state            <= DIAG_IDLE;
      cnt              <= '0;
      rd_q             <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      busy             <= 1'b0;
      ebus_ds          <= '0;
      ebus_diag_strobe <= 1'b0;
      ebus_data_out    <= '0;
      ebus_data_drive  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        DIAG_IDLE: begin
          if (req_valid && req_ready) begin
            state           <= DIAG_SETUP;
            cnt             <= SETUP_LD;
            rd_q            <= isDiagRead(req_func);
            busy            <= 1'b1;
            rsp_rdata       <= '0;
            ebus_ds         <= req_func;
            ebus_data_drive <= !isDiagRead(req_func);
            ebus_data_out   <= isDiagRead(req_func) ? 36'h0 : req_wdata;
          end
        end
        DIAG_SETUP: begin
          if (cnt == '0) begin
            state            <= DIAG_STROBE;
            cnt              <= STROBE_LD;
            ebus_diag_strobe <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIAG_STROBE: begin
          if (cnt == '0) begin
            state            <= DIAG_HOLD;
            cnt              <= HOLD_LD;
            ebus_diag_strobe <= 1'b0;
            if (rd_q) rsp_rdata <= ebus_data_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIAG_HOLD: begin
          if (cnt == '0) begin
            // Dropping ds to 0 hands CONSOLE CONTROL back to microcode.
            state           <= DIAG_DONE;
            rsp_valid       <= 1'b1;
            ebus_ds         <= '0;
            ebus_data_drive <= 1'b0;
            ebus_data_out   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIAG_DONE: begin
          state <= DIAG_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state            <= DIAG_IDLE;
          busy             <= 1'b0;
          ebus_ds          <= '0;
          ebus_diag_strobe <= 1'b0;
          ebus_data_drive  <= 1'b0;
          ebus_data_out    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebus_diag_seq.sv
// Directed bench for ebus_diag_seq: default-timing instance plus a S=T=H=1 instance.
module tb_ebus_diag_seq;
  import ebus_diag_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic        sel;
  logic [6:0]  req_func;
  logic [35:0] req_wdata;
  logic        ucode_diag;
  logic [35:0] ebus_data_in;

  logic        rdy_a, rv_a, bsy_a, stb_a, drv_a;
  logic [35:0] rd_a, do_a;
  logic [6:0]  ds_a;
  logic        rdy_b, rv_b, bsy_b, stb_b, drv_b;
  logic [35:0] rd_b, do_b;
  logic [6:0]  ds_b;

  logic        o_ready, o_rv, o_busy, o_stb, o_drv;
  logic [35:0] o_rdata, o_dout;
  logic [6:0]  o_ds;

  int          vec = 0;
  int          mis = 0;
  int          cyc = 0;
  logic [35:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  ebus_diag_seq dut_a (
    .CLK(clk), .RESET(rst),
    .req_valid(req_valid && !sel), .req_ready(rdy_a),
    .req_func(req_func), .req_wdata(req_wdata), .ucode_diag(ucode_diag),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .busy(bsy_a),
    .ebus_ds(ds_a), .ebus_diag_strobe(stb_a),
    .ebus_data_out(do_a), .ebus_data_drive(drv_a), .ebus_data_in(ebus_data_in)
  );

  ebus_diag_seq #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut_b (
    .CLK(clk), .RESET(rst),
    .req_valid(req_valid && sel), .req_ready(rdy_b),
    .req_func(req_func), .req_wdata(req_wdata), .ucode_diag(ucode_diag),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .busy(bsy_b),
    .ebus_ds(ds_b), .ebus_diag_strobe(stb_b),
    .ebus_data_out(do_b), .ebus_data_drive(drv_b), .ebus_data_in(ebus_data_in)
  );

  always_comb begin
    o_ready = sel ? rdy_b : rdy_a;
    o_rv    = sel ? rv_b  : rv_a;
    o_busy  = sel ? bsy_b : bsy_a;
    o_stb   = sel ? stb_b : stb_a;
    o_drv   = sel ? drv_b : drv_a;
    o_rdata = sel ? rd_b  : rd_a;
    o_dout  = sel ? do_b  : do_a;
    o_ds    = sel ? ds_b  : ds_a;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ds, strobe, drive, data_out, rsp_valid, busy, ready}
  function automatic logic [63:0] pack_obs();
    return {16'h0, o_ds, o_stb, o_drv, o_dout, o_rv, o_busy, o_ready};
  endfunction

  // Drives one request and checks every cycle from accept to the first idle cycle.
  task automatic send(input bit s, input logic [6:0] f, input logic [35:0] wd,
                      input logic [35:0] din_new, input bit ucode_mid, output int acc);
    int S, T, H, N, waited;
    bit rd, act, stb, drv, done;
    logic [35:0] exp_r, last_r;
    logic [63:0] ev;
    S = s ? 1 : 2;
    T = s ? 1 : 4;
    H = s ? 1 : 2;
    N = S + T + H + 1;
    rd = f[6];
    last_r = '0;
    sel = s; req_func = f; req_wdata = wd; ebus_data_in = 36'o1; req_valid = 1'b1;
    waited = 0;
    #1;
    while (!o_ready && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    chk("accept_ready", {63'h0, o_ready}, 64'h1);
    if (!o_ready) begin
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    exp_q.push_back(rd ? din_new : 36'h0);
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    for (int j = 1; j <= N + 1; j++) begin
      if (rd && j == S + T) ebus_data_in = din_new;
      if (ucode_mid && j == 2) ucode_diag = 1'b1;
      if (ucode_mid && j == N) ucode_diag = 1'b0;
      #1;
      act  = (j <= S + T + H);
      stb  = (j > S) && (j <= S + T);
      drv  = act && !rd;
      done = (j == N);
      ev = {16'h0, act ? f : 7'h0, stb, drv, drv ? wd : 36'h0, done,
            (j <= N), (j > N) && !ucode_diag};
      chk($sformatf("cyc_k+%0d_func%0o", j, f), pack_obs(), ev);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 64'h1, 64'h0);
        end else begin
          exp_r = exp_q.pop_front();
          last_r = exp_r;
          chk($sformatf("rdata_func%0o", f), {28'h0, o_rdata}, {28'h0, exp_r});
        end
      end
      if (j == N + 1) chk("rdata_hold", {28'h0, o_rdata}, {28'h0, last_r});
      if (j <= N) @(negedge clk);
    end
  endtask

  initial begin
    int acc1, acc2, cyc0;
    bit saw_rv;
    rst = 1'b1; req_valid = 1'b0; sel = 1'b0; req_func = '0; req_wdata = '0;
    ucode_diag = 1'b0; ebus_data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs_a", pack_obs(), 64'h1);
    chk("reset_rdata_a", {28'h0, rd_a}, 64'h0);
    sel = 1'b1; #1;
    chk("reset_outputs_b", pack_obs(), 64'h1);
    sel = 1'b0;
    ucode_diag = 1'b1; #1;
    chk("reset_ready_ucode", {63'h0, rdy_a}, 64'h0);
    ucode_diag = 1'b0;
    @(negedge clk);

    // Load 076; a microcode diag raised mid-cycle must not disturb it.
    send(1'b0, diagLdFunc076, 36'o000000_770000, 36'h0, 1'b1, acc1);
    // Read 100 with the bus changing only in the last strobe cycle.
    send(1'b0, 7'o100, 36'o777777_777777, 36'o123456_654321, 1'b0, acc1);

    // Microcode owns the port: a held request must wait.
    ucode_diag = 1'b1; sel = 1'b0; req_func = 7'o102; req_wdata = '0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("ucode_block_%0d", i), pack_obs(), 64'h0);
      @(negedge clk);
    end
    ucode_diag = 1'b0;
    cyc0 = cyc;
    send(1'b0, 7'o102, 36'h0, 36'o000000_000777, 1'b0, acc1);
    chk("ucode_release_accept", acc1, cyc0 + 1);

    // Reset in cycle k+4, in the middle of the strobe.
    sel = 1'b0; req_func = 7'o070; req_wdata = 36'o555555_000000; req_valid = 1'b1;
    #1;
    chk("abort_ready", {63'h0, o_ready}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_strobe_k4", {63'h0, o_stb}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_outputs", pack_obs(), 64'h1);
    saw_rv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (o_rv || o_busy) saw_rv = 1'b1;
    end
    chk("abort_no_rsp", {63'h0, saw_rv}, 64'h0);

    // Two queued requests: second accepted 10 cycles after the first.
    send(1'b0, 7'o070, 36'o123123_321321, 36'h0, 1'b0, acc1);
    send(1'b0, 7'o110, 36'h0, 36'o707070_070707, 1'b0, acc2);
    chk("b2b_spacing", acc2 - acc1, 64'd10);

    // Minimum timing instance.
    send(1'b1, 7'o104, 36'h0, 36'o246024_602460, 1'b0, acc1);
    send(1'b1, diagClkEdp, 36'o000001_000002, 36'h0, 1'b0, acc2);
    chk("fast_b2b_spacing", acc2 - acc1, 64'd5);

    chk("scoreboard_drained", exp_q.size(), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
